// File: rtl/pexg_multi_if.sv
// Channel bundle for pexg_multi: asynchronous inputs and per-channel
// controls going in, filtered level, edge pulses and event status coming out.
interface pexg_multi_if #(
    parameter int CH    = 4,
    parameter int CNT_W = 16
);
    logic [CH-1:0]       sig_in;
    logic [2*CH-1:0]     mode;
    logic [CH-1:0]       clr;
    logic [CH-1:0]       sig_filt;
    logic [CH-1:0]       pos_pulse;
    logic [CH-1:0]       neg_pulse;
    logic [CH-1:0]       evt_pulse;
    logic [CH-1:0]       evt_flag;
    logic [CH*CNT_W-1:0] evt_cnt;

    modport master (
        output sig_in, mode, clr,
        input  sig_filt, pos_pulse, neg_pulse, evt_pulse, evt_flag, evt_cnt
    );

    modport slave (
        input  sig_in, mode, clr,
        output sig_filt, pos_pulse, neg_pulse, evt_pulse, evt_flag, evt_cnt
    );
endinterface

// File: rtl/pexg_multi.sv
// Multi-channel edge/event detector: each channel synchronises an async
// input, glitch-filters it, emits rising/falling pulses, and keeps a
// mode-selected event pulse, sticky flag and saturating event counter.
module pexg_multi #(
    parameter int CH          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int CNT_W       = 16
) (
    input  logic          clk_fs,
    input  logic          rst,
    pexg_multi_if.slave   bus
);
    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [CH-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CH-1:0][FW-1:0]          fcnt_q, fcnt_d;
    logic [CH-1:0]                  sig_filt_q, sig_filt_d;
    logic [CH-1:0]                  pos_pulse_q, pos_pulse_d;
    logic [CH-1:0]                  neg_pulse_q, neg_pulse_d;
    logic [CH-1:0]                  evt_pulse_q, evt_pulse_d;
    logic [CH-1:0]                  evt_flag_q, evt_flag_d;
    logic [CH-1:0][CNT_W-1:0]       evt_cnt_q, evt_cnt_d;

    // Per-channel sync shift, filter counting, edge pulses and event bookkeeping.
    always_comb begin
        sync_d      = sync_q;
        fcnt_d      = fcnt_q;
        sig_filt_d  = sig_filt_q;
        pos_pulse_d = '0;
        neg_pulse_d = '0;
        evt_pulse_d = '0;
        evt_flag_d  = evt_flag_q;
        evt_cnt_d   = evt_cnt_q;
        for (int unsigned i = 0; i < CH; i++) begin
            sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], bus.sig_in[i]};

            if (sync_q[i][SYNC_STAGES-1] == sig_filt_q[i]) begin
                fcnt_d[i] = '0;
            end else if (fcnt_q[i] < FW'(FILTER_LEN - 1)) begin
                fcnt_d[i] = fcnt_q[i] + FW'(1);
            end else begin
                // Pulses are registered alongside the new level so they
                // coincide with the first cycle sig_filt shows it.
                sig_filt_d[i]  = ~sig_filt_q[i];
                fcnt_d[i]      = '0;
                pos_pulse_d[i] = ~sig_filt_q[i];
                neg_pulse_d[i] = sig_filt_q[i];
            end

            evt_pulse_d[i] = (bus.mode[2*i] & pos_pulse_d[i]) |
                             (bus.mode[2*i+1] & neg_pulse_d[i]);

            // A clear coinciding with a new event leaves that event counted.
            if (bus.clr[i]) begin
                evt_flag_d[i] = evt_pulse_d[i];
                evt_cnt_d[i]  = evt_pulse_d[i] ? CNT_W'(1) : '0;
            end else if (evt_pulse_d[i]) begin
                evt_flag_d[i] = 1'b1;
                if (evt_cnt_q[i] != '1) begin
                    evt_cnt_d[i] = evt_cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk_fs) begin
        if (rst) begin
            sync_q      <= '0;
            fcnt_q      <= '0;
            sig_filt_q  <= '0;
            pos_pulse_q <= '0;
            neg_pulse_q <= '0;
            evt_pulse_q <= '0;
            evt_flag_q  <= '0;
            evt_cnt_q   <= '0;
        end else begin
            sync_q      <= sync_d;
            fcnt_q      <= fcnt_d;
            sig_filt_q  <= sig_filt_d;
            pos_pulse_q <= pos_pulse_d;
            neg_pulse_q <= neg_pulse_d;
            evt_pulse_q <= evt_pulse_d;
            evt_flag_q  <= evt_flag_d;
            evt_cnt_q   <= evt_cnt_d;
        end
    end

    assign bus.sig_filt  = sig_filt_q;
    assign bus.pos_pulse = pos_pulse_q;
    assign bus.neg_pulse = neg_pulse_q;
    assign bus.evt_pulse = evt_pulse_q;
    assign bus.evt_flag  = evt_flag_q;
    assign bus.evt_cnt   = evt_cnt_q;

endmodule

// File: tb/tb_pexg_multi.sv
// Directed bench for pexg_multi with CH=4, SYNC_STAGES=2, FILTER_LEN=4, CNT_W=4.
module tb_pexg_multi;
    logic clk_fs = 1'b0;
    logic rst    = 1'b1;

    pexg_multi_if #(.CH(4), .CNT_W(4)) bus ();

    pexg_multi #(
        .CH(4),
        .SYNC_STAGES(2),
        .FILTER_LEN(4),
        .CNT_W(4)
    ) dut (
        .clk_fs(clk_fs),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk_fs = ~clk_fs;

    typedef struct {
        logic [3:0] in;
        logic [3:0] filt;
        logic [3:0] pos;
        logic [3:0] neg;
        logic [3:0] evt;
    } vec_t;

    vec_t tbl [11];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic tick();
        @(posedge clk_fs);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] cnt_of(input int ch);
        logic [15:0] all;
        all = bus.evt_cnt;
        return all[ch*4 +: 4];
    endfunction

    task automatic drive_ch(input int ch, input logic lvl);
        bus.sig_in[ch] = lvl;
        repeat (8) tick();
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, ".filt"}, 32'(bus.sig_filt), 32'h0);
        chk({name, ".pos"},  32'(bus.pos_pulse), 32'h0);
        chk({name, ".neg"},  32'(bus.neg_pulse), 32'h0);
        chk({name, ".evt"},  32'(bus.evt_pulse), 32'h0);
        chk({name, ".flag"}, 32'(bus.evt_flag), 32'h0);
        chk({name, ".cnt"},  32'(bus.evt_cnt), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pcnt, ncnt, ecnt, both, at;

        // ch0: step at edge 1; ch1: 3-cycle glitch; ch2: 4-cycle pulse (just accepted)
        tbl[0]  = '{4'b0111, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[1]  = '{4'b0111, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[2]  = '{4'b0111, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[3]  = '{4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[4]  = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[5]  = '{4'b0001, 4'b0101, 4'b0101, 4'b0000, 4'b0001};
        tbl[6]  = '{4'b0001, 4'b0101, 4'b0000, 4'b0000, 4'b0000};
        tbl[7]  = '{4'b0001, 4'b0101, 4'b0000, 4'b0000, 4'b0000};
        tbl[8]  = '{4'b0001, 4'b0101, 4'b0000, 4'b0000, 4'b0000};
        tbl[9]  = '{4'b0001, 4'b0001, 4'b0000, 4'b0100, 4'b0000};
        tbl[10] = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000};

        bus.sig_in = '0;
        bus.mode   = '0;
        bus.clr    = '0;
        rst        = 1'b1;
        repeat (2) tick();
        chk_all_zero("reset");

        rst      = 1'b0;
        bus.mode = 8'b00_00_00_01;
        for (int k = 0; k < 11; k++) begin
            bus.sig_in = tbl[k].in;
            tick();
            chk($sformatf("v%0d.filt", k + 1), 32'(bus.sig_filt),  32'(tbl[k].filt));
            chk($sformatf("v%0d.pos", k + 1),  32'(bus.pos_pulse), 32'(tbl[k].pos));
            chk($sformatf("v%0d.neg", k + 1),  32'(bus.neg_pulse), 32'(tbl[k].neg));
            chk($sformatf("v%0d.evt", k + 1),  32'(bus.evt_pulse), 32'(tbl[k].evt));
        end
        chk("glitch.cnt1", 32'(cnt_of(1)), 32'h0);
        chk("step.cnt0",   32'(cnt_of(0)), 32'h1);
        chk("step.flag0",  32'(bus.evt_flag[0]), 32'h1);
        chk("mode00.cnt2", 32'(cnt_of(2)), 32'h0);

        // clear alone, then saturation on ch0 rising edges
        bus.clr[0] = 1'b1;
        tick();
        bus.clr[0] = 1'b0;
        chk("clr.cnt0",  32'(cnt_of(0)), 32'h0);
        chk("clr.flag0", 32'(bus.evt_flag[0]), 32'h0);
        for (int r = 1; r <= 20; r++) begin
            drive_ch(0, 1'b0);
            drive_ch(0, 1'b1);
            if (r == 14) chk("sat.cnt0@14", 32'(cnt_of(0)), 32'd14);
            if (r == 15) chk("sat.cnt0@15", 32'(cnt_of(0)), 32'd15);
        end
        chk("sat.cnt0@20", 32'(cnt_of(0)), 32'd15);
        chk("sat.flag0",   32'(bus.evt_flag[0]), 32'h1);

        // ch2 both edges, then clear coincident with a third event
        bus.mode[5:4] = 2'b11;
        drive_ch(2, 1'b1);
        drive_ch(2, 1'b0);
        chk("both.cnt2",  32'(cnt_of(2)), 32'd2);
        chk("both.flag2", 32'(bus.evt_flag[2]), 32'h1);
        bus.sig_in[2] = 1'b1;
        repeat (5) tick();
        bus.clr[2] = 1'b1;
        tick();
        chk("clrevt.pos2",  32'(bus.pos_pulse[2]), 32'h1);
        chk("clrevt.evt2",  32'(bus.evt_pulse[2]), 32'h1);
        chk("clrevt.cnt2",  32'(cnt_of(2)), 32'd1);
        chk("clrevt.flag2", 32'(bus.evt_flag[2]), 32'h1);
        bus.clr[2] = 1'b0;
        tick();
        chk("clrevt.cnt2.hold", 32'(cnt_of(2)), 32'd1);

        // ch3 with mode 00: edges detected, no events
        pcnt = 0; ncnt = 0; ecnt = 0; both = 0;
        bus.sig_in[3] = 1'b1;
        for (int t = 0; t < 8; t++) begin
            tick();
            pcnt += int'(bus.pos_pulse[3]);
            ecnt += int'(bus.evt_pulse[3]);
            both += int'(bus.pos_pulse[3] & bus.neg_pulse[3]);
        end
        bus.sig_in[3] = 1'b0;
        for (int t = 0; t < 8; t++) begin
            tick();
            ncnt += int'(bus.neg_pulse[3]);
            ecnt += int'(bus.evt_pulse[3]);
            both += int'(bus.pos_pulse[3] & bus.neg_pulse[3]);
        end
        chk("m00.pos3",  32'(pcnt), 32'd1);
        chk("m00.neg3",  32'(ncnt), 32'd1);
        chk("m00.evt3",  32'(ecnt), 32'd0);
        chk("m00.both3", 32'(both), 32'd0);
        chk("m00.cnt3",  32'(cnt_of(3)), 32'd0);
        chk("m00.flag3", 32'(bus.evt_flag[3]), 32'h0);
        chk("indep.cnt2", 32'(cnt_of(2)), 32'd1);
        chk("indep.cnt0", 32'(cnt_of(0)), 32'd15);

        // reset two counts into a ch0 filter run, release with input held high
        drive_ch(0, 1'b0);
        bus.sig_in[0] = 1'b1;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        chk_all_zero("rst1");
        tick();
        chk_all_zero("rst2");
        rst  = 1'b0;
        pcnt = 0;
        at   = 0;
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (bus.pos_pulse[0]) begin
                pcnt++;
                at = t;
            end
        end
        chk("rstrel.pos0.count", 32'(pcnt), 32'd1);
        chk("rstrel.pos0.edge",  32'(at), 32'd6);
        chk("rstrel.filt0",      32'(bus.sig_filt[0]), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
